// File: rtl/add_rr_sched.sv
// Round-robin scheduler sharing one adder among NREQ requesters.
// One response slot; grant and consume may happen in the same cycle.

module adder_nbit #(
    parameter int WIDTH     = 32,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] s_o
);

    generate
        if (IMPL_TYPE == 0) begin : g_behav
            assign s_o = a_i + b_i;
        end else begin : g_ripple
            logic [WIDTH-1:0] c;
            assign c[0] = 1'b0;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                assign s_o[i] = a_i[i] ^ b_i[i] ^ c[i];
                if (i < WIDTH - 1) begin : g_cy
                    assign c[i+1] = (a_i[i] & b_i[i]) |
                                    (c[i] & (a_i[i] ^ b_i[i]));
                end
            end
        end
    endgenerate

endmodule

module add_rr_sched #(
    parameter int WIDTH     = 32,
    parameter int NREQ      = 4,
    parameter int IMPL_TYPE = 0,
    localparam int IDW      = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic [IDW-1:0]        rsp_id,
    output logic [31:0]           ops_done
);

    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [31:0]      ops_done_q, ops_done_d;

    logic             found;
    logic [IDW-1:0]   win;
    logic             can_accept;
    logic             grant;
    logic             consume;
    logic [WIDTH-1:0] a_sel, b_sel, sum;

    assign can_accept = !rsp_valid_q | rsp_ready;
    assign consume    = rsp_valid_q & rsp_ready;

    // Pick the first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    // Only the winner sees ready, and only when the slot can take a result.
    always_comb begin
        req_ready = '0;
        if (found) req_ready[win] = can_accept;
    end

    assign grant = found & can_accept;
    assign a_sel = req_a[int'(win)*WIDTH +: WIDTH];
    assign b_sel = req_b[int'(win)*WIDTH +: WIDTH];

    adder_nbit #(
        .WIDTH    (WIDTH),
        .IMPL_TYPE(IMPL_TYPE)
    ) u_add (
        .a_i(a_sel),
        .b_i(b_sel),
        .s_o(sum)
    );

    // Slot state (EMPTY/FULL via rsp_valid), payload, pointer, counter.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        rr_ptr_d    = rr_ptr_q;
        ops_done_d  = ops_done_q;
        if (consume) begin
            rsp_valid_d = 1'b0;
            ops_done_d  = ops_done_q + 32'd1;
        end
        if (grant) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = sum;
            rsp_id_d    = win;
            rr_ptr_d    = IDW'((int'(win) + 1) % NREQ);
        end
    end

    // State registers; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
            ops_done_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_add_rr_sched.sv
// Scoreboard bench for add_rr_sched.
// Directed stimulus pushes expected responses; a monitor checks them.

module tb_add_rr_sched;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_sum;
    logic [1:0]     rsp_id;
    logic [31:0]    ops_done;

    int checks;
    int fails;

    typedef struct packed {
        logic [W-1:0] sum;
        logic [1:0]   id;
    } exp_t;

    exp_t sb[$];

    add_rr_sched #(.WIDTH(W), .NREQ(N), .IMPL_TYPE(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_sum  (rsp_sum),
        .rsp_id   (rsp_id),
        .ops_done (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] s, input logic [1:0] id);
        exp_t e;
        e.sum = s;
        e.id  = id;
        sb.push_back(e);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // Monitor: every consumed response must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL mon_unexpected: got id %0d sum %0h expected none",
                         rsp_id, rsp_sum);
            end else begin
                e = sb.pop_front();
                if (rsp_sum !== e.sum || rsp_id !== e.id) begin
                    fails++;
                    $display("FAIL mon_rsp: got id %0d sum %0h expected id %0d sum %0h",
                             rsp_id, rsp_sum, e.id, e.sum);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] hold_sum;
        checks    = 0;
        fails     = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_sum", rsp_sum, 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_ops", ops_done, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        step();

        // Single request from requester 1.
        set_op(1, 32'd5, 32'd7);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        chk("t1_ready", 32'(req_ready), 32'b0010);
        push(32'd12, 2'd1);
        step();
        req_valid = '0;
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        chk("t1_sum", rsp_sum, 32'd12);
        chk("t1_id", 32'(rsp_id), 32'd1);
        step();
        chk("t1_ops", ops_done, 32'd1);
        chk("t1_empty", 32'(rsp_valid), 32'd0);

        // Reset so the pointer starts at 0, then all four valid.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++)
            set_op(i, 32'(100 * i + 1), 32'(i + 10));
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            push(32'(100 * (k % 4) + 1 + (k % 4) + 10), 2'(k % 4));
            step();
        end
        req_valid = '0;
        step();
        chk("t2_ops", ops_done, 32'd6);
        chk("t2_empty", 32'(rsp_valid), 32'd0);

        // Backpressure: pointer is now 2.
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("t3_ready0", 32'(req_ready), 32'b0100);
        push(32'd213, 2'd2);
        step();
        hold_sum = rsp_sum;
        for (int k = 0; k < 3; k++) begin
            chk("t3_stall_ready", 32'(req_ready), 32'd0);
            chk("t3_stall_id", 32'(rsp_id), 32'd2);
            chk("t3_stall_sum", rsp_sum, 32'd213);
            step();
        end
        chk("t3_hold", rsp_sum, hold_sum);
        rsp_ready = 1'b1;
        #1;
        chk("t3_nobubble", 32'(req_ready), 32'b1000);
        push(32'd314, 2'd3);
        step();
        req_valid = '0;
        chk("t3_valid", 32'(rsp_valid), 32'd1);
        step();
        chk("t3_ops", ops_done, 32'd8);

        // Overflow and pointer wrap.
        set_op(3, 32'hFFFF_FFFF, 32'h0000_0002);
        req_valid = 4'b1000;
        push(32'h0000_0001, 2'd3);
        step();
        req_valid = 4'b1001;
        #1;
        chk("t4_wrap_ready", 32'(req_ready), 32'b0001);
        push(32'd11, 2'd0);
        step();
        req_valid = '0;
        step();
        chk("t4_ops", ops_done, 32'd10);

        // Reset while a response is stalled.
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        push(32'd213, 2'd2);
        step();
        req_valid = '0;
        chk("t5_full", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(rsp_valid), 32'd0);
        chk("t5_async_ops", ops_done, 32'd0);
        sb.delete();
        rst_n = 1'b1;
        step();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("t5_ptr0", 32'(req_ready), 32'b0001);
        push(32'd11, 2'd0);
        step();
        req_valid = '0;
        step();
        chk("t5_ops", ops_done, 32'd1);

        // Counter wrap.
        force dut.ops_done_q = 32'hFFFF_FFFF;
        #1;
        release dut.ops_done_q;
        #1;
        chk("t6_pre", ops_done, 32'hFFFF_FFFF);
        req_valid = 4'b0001;
        push(32'd11, 2'd0);
        step();
        req_valid = '0;
        step();
        chk("t6_wrap", ops_done, 32'd0);

        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
